long_inst_scoreboard: RTL and testbench

LONG_INST_SCOREBOARD -- requirements
Module: long_inst_scoreboard

---
 rtl/lisb_pkg.sv | 16 +
 rtl/lisb_free_enc.sv | 23 ++
 rtl/long_inst_scoreboard.sv | 136 +++++++++++++
 tb/tb_long_inst_scoreboard.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisb_pkg.sv
// Shared definitions for the long-instruction scoreboard.
package lisb_pkg;

  localparam int unsigned LISB_DEPTH      = 8;
  localparam int unsigned LISB_NUM_COMMIT = 2;
  localparam int unsigned REG_ADDR_WIDTH  = 5;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

  // One outstanding long instruction: rd is only meaningful while valid is set.
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } lisb_entry_t;

endpackage

// File: rtl/lisb_free_enc.sv
// Lowest-index free slot encoder for the long-instruction scoreboard.
module lisb_free_enc #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ID_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] free_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (free_i[i-1]) begin
        idx_o   = ID_W'(i - 1);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/long_inst_scoreboard.sv
// Scoreboard tracking outstanding long-latency instructions: detects RAW/WAW
// hazards for the issuing instruction, grants entry IDs, retires on commit.
module long_inst_scoreboard
  import lisb_pkg::*;
#(
  parameter int unsigned DEPTH         = LISB_DEPTH,
  parameter int unsigned NUM_COMMIT    = LISB_NUM_COMMIT,
  parameter int unsigned COMMIT_BYPASS = 1,
  parameter int unsigned ID_W          = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]  rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]  rs2_addr_i,
  input  logic                       rd_we_i,
  input  logic [NUM_COMMIT-1:0]      commit_valid_i,
  input  logic [NUM_COMMIT*ID_W-1:0] commit_id_i,
  input  logic                       flush_i,
  output logic                       hold_o,
  output logic [ID_W-1:0]            alloc_id_o,
  output logic [ID_W:0]              occ_cnt_o,
  output logic                       full_o,
  output logic                       busy_o,
  output logic                       err_o
);

  lisb_entry_t       ent_q [DEPTH];
  logic [ID_W:0]     occ_q, occ_d;
  logic              err_q;

  logic [DEPTH-1:0]  valid_vec;
  logic [DEPTH-1:0]  commit_hit;
  logic [DEPTH-1:0]  commit_clr;
  logic [DEPTH-1:0]  live_vec;
  logic [ID_W:0]     n_commit;
  logic              err_set;
  logic              raw, waw;
  logic              rd_chk;
  logic              found;
  logic              alloc_go;
  reg_addr_t         rd_store;

  // Flatten entry valid bits for the encoder and commit logic.
  always_comb begin
    valid_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
    end
  end

  // Free-slot selection uses start-of-cycle state, so a slot committed this
  // cycle is not handed out until the next one.
  lisb_free_enc #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_free_enc (
    .free_i  (~valid_vec),
    .idx_o   (alloc_id_o),
    .found_o (found)
  );

  // Decode commit ports into a one-hot-per-entry mask; duplicate IDs merge.
  always_comb begin
    commit_hit = '0;
    for (int unsigned k = 0; k < NUM_COMMIT; k++) begin
      if (commit_valid_i[k]) begin
        commit_hit[commit_id_i[k*ID_W +: ID_W]] = 1'b1;
      end
    end
  end

  assign commit_clr = commit_hit & valid_vec;
  assign err_set    = !flush_i && |(commit_hit & ~valid_vec);
  assign live_vec   = (COMMIT_BYPASS != 0) ? (valid_vec & ~commit_hit) : valid_vec;
  assign rd_chk     = rd_we_i && (rd_addr_i != '0);

  // Count distinct valid entries retired this cycle.
  always_comb begin
    n_commit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      n_commit = n_commit + (ID_W+1)'(commit_clr[i]);
    end
  end

  // RAW/WAW against live entries; x0 is never checked and stored x0 never matches.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_vec[i]) begin
        if ((rs1_addr_i != '0) && (ent_q[i].rd == rs1_addr_i)) raw = 1'b1;
        if ((rs2_addr_i != '0) && (ent_q[i].rd == rs2_addr_i)) raw = 1'b1;
        if (rd_chk && (ent_q[i].rd == rd_addr_i))              waw = 1'b1;
      end
    end
  end

  assign full_o    = (occ_q == (ID_W+1)'(DEPTH));
  assign busy_o    = (occ_q != '0);
  assign occ_cnt_o = occ_q;
  assign err_o     = err_q;
  assign hold_o    = alloc_valid_i && !flush_i && (raw || waw || full_o);
  assign alloc_go  = alloc_valid_i && !hold_o && found;
  assign rd_store  = rd_chk ? rd_addr_i : '0;
  assign occ_d     = occ_q - n_commit + (ID_W+1)'(alloc_go);

  // Entry table, occupancy and sticky error; flush overrides alloc and commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      occ_q <= '0;
      err_q <= 1'b0;
    end else if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (alloc_go && (alloc_id_o == ID_W'(i))) begin
          ent_q[i].valid <= 1'b1;
          ent_q[i].rd    <= rd_store;
        end else if (commit_clr[i]) begin
          ent_q[i].valid <= 1'b0;
        end
      end
      occ_q <= occ_d;
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_long_inst_scoreboard.sv
// Self-checking bench for long_inst_scoreboard with a reference model feeding
// an expected-value queue.
module tb_long_inst_scoreboard;
  import lisb_pkg::*;

  localparam int DEPTH = 8;
  localparam int NC    = 2;
  localparam int IDW   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            av, we, fl;
  logic [4:0]      rd, rs1, rs2;
  logic [NC-1:0]   cv;
  logic [IDW-1:0]  cid [NC];
  logic [NC*IDW-1:0] cid_bus;
  logic            hold_o, full_o, busy_o, err_o;
  logic [IDW-1:0]  alloc_id_o;
  logic [IDW:0]    occ_cnt_o;

  assign cid_bus = {cid[1], cid[0]};

  always #5 clk = ~clk;

  long_inst_scoreboard #(
    .DEPTH         (DEPTH),
    .NUM_COMMIT    (NC),
    .COMMIT_BYPASS (1),
    .ID_W          (IDW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid_i  (av),
    .rd_addr_i      (rd),
    .rs1_addr_i     (rs1),
    .rs2_addr_i     (rs2),
    .rd_we_i        (we),
    .commit_valid_i (cv),
    .commit_id_i    (cid_bus),
    .flush_i        (fl),
    .hold_o         (hold_o),
    .alloc_id_o     (alloc_id_o),
    .occ_cnt_o      (occ_cnt_o),
    .full_o         (full_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  bit  m_valid [DEPTH];
  int  m_rd    [DEPTH];
  int  m_occ;
  bit  m_err;

  logic           obs_hold;
  logic [IDW-1:0] obs_id;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input int v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  function automatic bit m_hit(input int j);
    for (int k = 0; k < NC; k++)
      if (cv[k] && int'(cid[k]) == j) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hold();
    if (!av || fl) return 1'b0;
    if (m_occ == DEPTH) return 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      if (m_valid[j] && !m_hit(j)) begin
        if (rs1 != 0 && m_rd[j] == int'(rs1)) return 1'b1;
        if (rs2 != 0 && m_rd[j] == int'(rs2)) return 1'b1;
        if (we && rd != 0 && m_rd[j] == int'(rd)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int m_free();
    for (int j = 0; j < DEPTH; j++)
      if (!m_valid[j]) return j;
    return 0;
  endfunction

  task automatic m_reset();
    for (int j = 0; j < DEPTH; j++) begin
      m_valid[j] = 1'b0;
      m_rd[j]    = 0;
    end
    m_occ = 0;
    m_err = 1'b0;
  endtask

  task automatic m_step(input bit hold);
    int f;
    if (fl) begin
      for (int j = 0; j < DEPTH; j++) m_valid[j] = 1'b0;
      m_occ = 0;
    end else begin
      f = m_free();
      for (int j = 0; j < DEPTH; j++) begin
        if (m_hit(j)) begin
          if (m_valid[j]) begin
            m_valid[j] = 1'b0;
            m_occ--;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      if (av && !hold) begin
        m_valid[f] = 1'b1;
        m_rd[f]    = (we && rd != 0) ? int'(rd) : 0;
        m_occ++;
      end
    end
  endtask

  task automatic idle();
    av = 0; we = 0; fl = 0; rd = 0; rs1 = 0; rs2 = 0; cv = '0;
    cid[0] = '0; cid[1] = '0;
  endtask

  // One clock: combinational outputs checked before the edge, registered after.
  task automatic cyc();
    bit eh;
    int eid;
    #1;
    eh  = m_hold();
    eid = m_free();
    sb_push("hold", int'(eh));
    if (av && !eh) sb_push("alloc_id", eid);
    obs_hold = hold_o;
    obs_id   = alloc_id_o;
    sb_pop_check(32'(obs_hold));
    if (av && !eh) sb_pop_check(32'(obs_id));
    @(posedge clk);
    m_step(eh);
    @(negedge clk);
    sb_push("occ", m_occ);
    sb_push("full", int'(m_occ == DEPTH));
    sb_push("busy", int'(m_occ != 0));
    sb_push("err", int'(m_err));
    sb_pop_check(32'(occ_cnt_o));
    sb_pop_check(32'(full_o));
    sb_pop_check(32'(busy_o));
    sb_pop_check(32'(err_o));
  endtask

  task automatic alloc(input int r);
    idle(); av = 1; we = 1; rd = 5'(r);
    cyc();
  endtask

  task automatic flush();
    idle(); fl = 1;
    cyc();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    m_reset();
    #1;
    check_eq("rst_occ",   32'(occ_cnt_o), 0);
    check_eq("rst_full",  32'(full_o), 0);
    check_eq("rst_busy",  32'(busy_o), 0);
    check_eq("rst_err",   32'(err_o), 0);
    check_eq("rst_hold",  32'(hold_o), 0);
    check_eq("rst_id",    32'(alloc_id_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW hold then same-cycle commit bypass
    alloc(5);
    check_eq("raw_first_id", 32'(obs_id), 0);
    idle(); av = 1; we = 1; rd = 10; rs1 = 5;
    cyc();
    check_eq("raw_hold", 32'(obs_hold), 1);
    cv = 2'b01; cid[0] = 0;
    cyc();
    check_eq("bypass_hold", 32'(obs_hold), 0);
    check_eq("bypass_id", 32'(obs_id), 1);
    flush();

    // Fill to full, hold, then reuse committed slot
    for (int i = 1; i <= 8; i++) alloc(i);
    check_eq("fill_occ", 32'(occ_cnt_o), 8);
    check_eq("fill_full", 32'(full_o), 1);
    alloc(9);
    check_eq("full_hold", 32'(obs_hold), 1);
    idle(); cv = 2'b01; cid[0] = 3;
    cyc();
    alloc(9);
    check_eq("reuse_hold", 32'(obs_hold), 0);
    check_eq("reuse_id", 32'(obs_id), 3);
    flush();

    // Duplicate commit counts once; invalid commit sets sticky error
    for (int i = 1; i <= 4; i++) alloc(i);
    idle(); cv = 2'b11; cid[0] = 2; cid[1] = 2;
    cyc();
    check_eq("dup_commit_occ", 32'(occ_cnt_o), 3);
    idle(); cv = 2'b01; cid[0] = 6;
    cyc();
    check_eq("bad_commit_err", 32'(err_o), 1);
    check_eq("bad_commit_occ", 32'(occ_cnt_o), 3);
    idle();
    cyc();
    check_eq("err_sticky", 32'(err_o), 1);
    flush();

    // Flush overrides same-cycle alloc
    for (int i = 11; i <= 15; i++) alloc(i);
    idle(); av = 1; we = 1; rd = 20; rs1 = 11; fl = 1;
    cyc();
    check_eq("flush_occ", 32'(occ_cnt_o), 0);
    check_eq("flush_busy", 32'(busy_o), 0);
    idle(); av = 1; we = 1; rd = 13; rs1 = 11; rs2 = 12;
    cyc();
    check_eq("post_flush_hold", 32'(obs_hold), 0);
    check_eq("post_flush_id", 32'(obs_id), 0);

    // x0 handling and WAW
    alloc(0);
    check_eq("x0_occ", 32'(occ_cnt_o), 2);
    idle(); av = 1; we = 1;
    cyc();
    check_eq("x0_src_hold", 32'(obs_hold), 0);
    alloc(13);
    check_eq("waw_hold", 32'(obs_hold), 1);
    idle(); av = 1; we = 0; rd = 13;
    cyc();
    check_eq("no_we_hold", 32'(obs_hold), 0);
    flush();

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      av  = ($urandom_range(0, 9) < 7);
      we  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      cv  = 2'($urandom_range(0, 3));
      cid[0] = 3'($urandom_range(0, 7));
      cid[1] = 3'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 39) == 0);
      cyc();
    end
    flush();

    // Asynchronous reset mid-cycle
    for (int i = 1; i <= 3; i++) alloc(i);
    check_eq("pre_rst_occ", 32'(occ_cnt_o), 3);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_occ",  32'(occ_cnt_o), 0);
    check_eq("async_rst_err",  32'(err_o), 0);
    check_eq("async_rst_busy", 32'(busy_o), 0);
    check_eq("async_rst_id",   32'(alloc_id_o), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    alloc(3);
    check_eq("post_rst_id", 32'(obs_id), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
